// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding, frame bit levels and scan-code prefixes for the PS/2 receiver.
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
    localparam logic PS2_START_BIT = 1'b0;
    localparam logic PS2_STOP_BIT = 1'b1;
    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
    function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: synchronises both PS/2 pins, de-glitches the clock and flags its falling edge.
module ps2_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic data
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic [FW-1:0] cnt;
    logic filt, settle;
    // cnt tracks how long the synchronised clock has disagreed with the filtered level
    assign settle = clk_sync[SYNC_STAGES-1] != filt && cnt == FW'(FILTER_LEN - 1);
    assign data = data_sync[SYNC_STAGES-1];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= '1;
            data_sync <= '1;
            filt <= 1'b1;
            cnt <= '0;
            fall <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            cnt <= (clk_sync[SYNC_STAGES-1] == filt || settle) ? '0 : cnt + 1'b1;
            filt <= settle ? clk_sync[SYNC_STAGES-1] : filt;
            fall <= settle & filt;
        end
    end
endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 device-to-host frame receiver with parity/stop/timeout checking.
// Define PS2_KEY_DECODE_EN to fold E0/F0 prefixes into KEY_EXTENDED/KEY_RELEASED flags.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic       CLK_25MHZ,
    input  logic       RESET_N,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] SCAN_CODE,
    output logic       SCAN_VALID,
    output logic       FRAME_ERROR,
`ifdef PS2_KEY_DECODE_EN
    output logic       KEY_RELEASED,
    output logic       KEY_EXTENDED,
`endif
    output logic       BUSY
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    ps2_state_t state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shreg, shreg_n, code_n;
    logic [TW-1:0] tcnt;
    logic par, par_n, valid_n, err_n, fall, data, frame_ok, expire;
`ifdef PS2_KEY_DECODE_EN
    logic pend_rel, pend_ext, pend_rel_n, pend_ext_n, rel_n, ext_n;
`endif

    ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filter (
        .clk(CLK_25MHZ),
        .rst_n(RESET_N),
        .ps2_clk(PS2_CLK),
        .ps2_data(PS2_DATA),
        .fall(fall),
        .data(data)
    );

    assign frame_ok = data == PS2_STOP_BIT && odd_parity_ok(shreg, par);
    assign expire = state != IDLE && tcnt == TW'(TIMEOUT_CYCLES - 1);
    assign BUSY = state != IDLE;

    always_comb begin
        state_n = state;
        bit_cnt_n = bit_cnt;
        shreg_n = shreg;
        par_n = par;
        valid_n = 1'b0;
        err_n = 1'b0;
        code_n = SCAN_CODE;
        if (fall) begin
            case (state)
                IDLE: begin
                    state_n = data == PS2_START_BIT ? DATA : IDLE;
                    err_n = data != PS2_START_BIT;
                    bit_cnt_n = '0;
                    shreg_n = '0;
                end
                DATA: begin
                    shreg_n[bit_cnt] = data;
                    bit_cnt_n = bit_cnt + 1'b1;
                    state_n = bit_cnt == 3'd7 ? PARITY : DATA;
                end
                PARITY: begin
                    par_n = data;
                    state_n = STOP;
                end
                default: begin
                    state_n = IDLE;
                    valid_n = frame_ok;
                    err_n = !frame_ok;
                    code_n = frame_ok ? shreg : SCAN_CODE;
                end
            endcase
        end else if (expire) begin
            state_n = IDLE;
            err_n = 1'b1;
            shreg_n = '0;
        end
`ifdef PS2_KEY_DECODE_EN
        pend_rel_n = pend_rel;
        pend_ext_n = pend_ext;
        rel_n = KEY_RELEASED;
        ext_n = KEY_EXTENDED;
        // prefixes only arm flags; the following make/break code carries them out
        if (valid_n && (shreg == PS2_EXT_PREFIX || shreg == PS2_BREAK_PREFIX)) begin
            pend_ext_n = pend_ext | (shreg == PS2_EXT_PREFIX);
            pend_rel_n = pend_rel | (shreg == PS2_BREAK_PREFIX);
            valid_n = 1'b0;
            code_n = SCAN_CODE;
        end else if (valid_n) begin
            rel_n = pend_rel;
            ext_n = pend_ext;
            pend_rel_n = 1'b0;
            pend_ext_n = 1'b0;
        end
        if (err_n) begin
            pend_rel_n = 1'b0;
            pend_ext_n = 1'b0;
        end
`endif
    end

    always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            bit_cnt <= '0;
            shreg <= '0;
            par <= 1'b0;
            tcnt <= '0;
            SCAN_CODE <= '0;
            SCAN_VALID <= 1'b0;
            FRAME_ERROR <= 1'b0;
        end else begin
            state <= state_n;
            bit_cnt <= bit_cnt_n;
            shreg <= shreg_n;
            par <= par_n;
            tcnt <= (fall || state == IDLE) ? '0 : (tcnt == '1 ? tcnt : tcnt + 1'b1);
            SCAN_CODE <= code_n;
            SCAN_VALID <= valid_n;
            FRAME_ERROR <= err_n;
        end
    end

`ifdef PS2_KEY_DECODE_EN
    always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            pend_rel <= 1'b0;
            pend_ext <= 1'b0;
            KEY_RELEASED <= 1'b0;
            KEY_EXTENDED <= 1'b0;
        end else begin
            pend_rel <= pend_rel_n;
            pend_ext <= pend_ext_n;
            KEY_RELEASED <= rel_n;
            KEY_EXTENDED <= ext_n;
        end
    end
`endif
endmodule
